// File: rtl/defender_input_pkg.sv
// Shared constants for the Defender input block: key codes, button bit positions
// and the coin-shaper state encoding.
package defender_input_pkg;

  localparam int BTN_W           = 12;
  localparam int BTN_ADVANCE     = 0;
  localparam int BTN_AUTO_UP     = 1;
  localparam int BTN_SCORE_RESET = 2;
  localparam int BTN_ONE_PLAYER  = 3;
  localparam int BTN_TWO_PLAYERS = 4;
  localparam int BTN_FIRE        = 5;
  localparam int BTN_THRUST      = 6;
  localparam int BTN_SMART_BOMB  = 7;
  localparam int BTN_HYPERSPACE  = 8;
  localparam int BTN_REVERSE     = 9;
  localparam int BTN_DOWN        = 10;
  localparam int BTN_UP          = 11;

  // Keyboard latch vector: the twelve button latches plus the coin latch on top.
  localparam int KB_COIN = 12;
  localparam int KB_W    = 13;

  // 9-bit key codes: {extended, scan code}
  localparam logic [8:0] KEY_UP          = 9'h175;
  localparam logic [8:0] KEY_DOWN        = 9'h172;
  localparam logic [8:0] KEY_THRUST_A    = 9'h16B;
  localparam logic [8:0] KEY_THRUST_B    = 9'h174;
  localparam logic [8:0] KEY_REVERSE_A   = 9'h012;
  localparam logic [8:0] KEY_REVERSE_B   = 9'h059;
  localparam logic [8:0] KEY_FIRE        = 9'h029;
  localparam logic [8:0] KEY_ONE_PLAYER  = 9'h005;
  localparam logic [8:0] KEY_TWO_PLAYERS = 9'h006;
  localparam logic [8:0] KEY_COIN        = 9'h004;
  localparam logic [8:0] KEY_SMART_BOMB  = 9'h114;
  localparam logic [8:0] KEY_HYPERSPACE  = 9'h01D;
  localparam logic [8:0] KEY_ADVANCE     = 9'h01C;
  localparam logic [8:0] KEY_AUTO_UP     = 9'h03C;
  localparam logic [8:0] KEY_SCORE_RESET = 9'h033;

  typedef enum logic [1:0] {
    COIN_IDLE     = 2'd0,
    COIN_PULSE    = 2'd1,
    COIN_GAP      = 2'd2,
    COIN_WAIT_REL = 2'd3
  } coin_state_t;

endpackage

// File: rtl/defender_coin_shaper.sv
// Turns a rising edge of coin_src into one fixed-width coin pulse followed by a
// mandatory low gap; a held coin must be released before another pulse.
module defender_coin_shaper
  import defender_input_pkg::*;
#(
  parameter int COIN_PULSE_CYC = 600000,
  parameter int COIN_GAP_CYC   = 300000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        coin_src,
  input  logic        hold,
  output logic        coin_out,
  output coin_state_t state
);

  localparam int CNT_MAX = (COIN_PULSE_CYC > COIN_GAP_CYC) ? COIN_PULSE_CYC : COIN_GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  logic [CW-1:0] cnt;
  logic          src_q;

  // Edges seen outside IDLE are simply lost; src_q keeps tracking so that a coin
  // held across a pulse or a hold never looks like a fresh edge later.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= COIN_IDLE;
      cnt      <= '0;
      coin_out <= 1'b0;
      src_q    <= 1'b0;
    end else begin
      src_q <= coin_src;
      if (hold) begin
        state    <= COIN_IDLE;
        cnt      <= '0;
        coin_out <= 1'b0;
      end else begin
        case (state)
          COIN_IDLE: begin
            if (coin_src && !src_q) begin
              state    <= COIN_PULSE;
              cnt      <= CW'(COIN_PULSE_CYC - 1);
              coin_out <= 1'b1;
            end
          end
          COIN_PULSE: begin
            if (cnt == '0) begin
              state    <= COIN_GAP;
              cnt      <= CW'(COIN_GAP_CYC - 1);
              coin_out <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          COIN_GAP: begin
            if (cnt == '0) begin
              state <= coin_src ? COIN_WAIT_REL : COIN_IDLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          COIN_WAIT_REL: begin
            if (!coin_src) state <= COIN_IDLE;
          end
          default: state <= COIN_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/defender_input_ctrl.sv
// Defender input block: PS/2 key latches merged with joysticks into btn, a shaped
// coin pulse, and a stretched core reset.
module defender_input_ctrl
  import defender_input_pkg::*;
#(
  parameter int COIN_PULSE_CYC = 600000,
  parameter int COIN_GAP_CYC   = 300000,
  parameter int RST_HOLD_CYC   = 1024
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [64:0]      ps2_key,
  input  logic [15:0]      joystick_0,
  input  logic [15:0]      joystick_1,
  input  logic             reset_req,
  output logic [BTN_W-1:0] btn,
  output logic             coin_out,
  output logic             core_reset
);

  localparam int HCW = $clog2(RST_HOLD_CYC) + 1;

  logic              toggle_q;
  logic [KB_W-1:0]   kb_q;
  logic [KB_W-1:0]   kb_d;
  logic [HCW-1:0]    hold_cnt;
  logic [HCW-1:0]    hold_cnt_d;
  logic              rst_d;
  logic [15:0]       joy;
  logic [BTN_W-1:0]  joy_btn;
  logic [BTN_W-1:0]  btn_d;
  logic              key_event;
  logic              key_pressed;
  logic              key_ext;
  logic [8:0]        key_code;
  logic              coin_src;
  coin_state_t       coin_state;
  logic              unused_bits;

  assign joy         = joystick_0 | joystick_1;
  assign key_event   = (ps2_key[64] != toggle_q) && (ps2_key[63:24] == '0);
  assign key_pressed = (ps2_key[15:8] != 8'hF0);
  assign key_ext     = (ps2_key[15:8] == 8'hE0) || (ps2_key[23:16] == 8'hE0);
  assign key_code    = {key_ext, ps2_key[7:0]};

  // Next core_reset: reset_req reloads the full hold, so a re-assert restarts it.
  always_comb begin
    hold_cnt_d = '0;
    rst_d      = 1'b0;
    if (reset_req) begin
      hold_cnt_d = HCW'(RST_HOLD_CYC);
      rst_d      = 1'b1;
    end else if (hold_cnt != '0) begin
      hold_cnt_d = hold_cnt - 1'b1;
      rst_d      = 1'b1;
    end
  end

  always_comb begin
    kb_d = kb_q;
    if (rst_d) begin
      kb_d = '0;
    end else if (key_event) begin
      case (key_code)
        KEY_UP:                       kb_d[BTN_UP]          = key_pressed;
        KEY_DOWN:                     kb_d[BTN_DOWN]        = key_pressed;
        KEY_THRUST_A, KEY_THRUST_B:   kb_d[BTN_THRUST]      = key_pressed;
        KEY_REVERSE_A, KEY_REVERSE_B: kb_d[BTN_REVERSE]     = key_pressed;
        KEY_FIRE:                     kb_d[BTN_FIRE]        = key_pressed;
        KEY_ONE_PLAYER:               kb_d[BTN_ONE_PLAYER]  = key_pressed;
        KEY_TWO_PLAYERS:              kb_d[BTN_TWO_PLAYERS] = key_pressed;
        KEY_COIN:                     kb_d[KB_COIN]         = key_pressed;
        KEY_SMART_BOMB:               kb_d[BTN_SMART_BOMB]  = key_pressed;
        KEY_HYPERSPACE:               kb_d[BTN_HYPERSPACE]  = key_pressed;
        KEY_ADVANCE:                  kb_d[BTN_ADVANCE]     = key_pressed;
        KEY_AUTO_UP:                  kb_d[BTN_AUTO_UP]     = key_pressed;
        KEY_SCORE_RESET:              kb_d[BTN_SCORE_RESET] = key_pressed;
        default: ;
      endcase
    end
  end

  always_comb begin
    joy_btn                 = '0;
    joy_btn[BTN_FIRE]       = joy[5];
    joy_btn[BTN_THRUST]     = joy[0] | joy[1];
    joy_btn[BTN_SMART_BOMB] = joy[6];
    joy_btn[BTN_HYPERSPACE] = joy[7];
    joy_btn[BTN_REVERSE]    = joy[4];
    joy_btn[BTN_DOWN]       = joy[2];
    joy_btn[BTN_UP]         = joy[3];
    joy_btn[BTN_ONE_PLAYER] = joy[8];
  end

  // btn is built from next-state latches so a key event shows up one cycle later.
  assign btn_d    = kb_d[BTN_W-1:0] | joy_btn;
  assign coin_src = kb_q[KB_COIN] | joy[9];

  // Reset loads RST_HOLD_CYC-1 because core_reset is already high in the cycle
  // reset_n rises, giving exactly RST_HOLD_CYC high cycles afterwards.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q   <= 1'b0;
      kb_q       <= '0;
      btn        <= '0;
      hold_cnt   <= HCW'(RST_HOLD_CYC - 1);
      core_reset <= 1'b1;
    end else begin
      toggle_q   <= ps2_key[64];
      kb_q       <= kb_d;
      btn        <= btn_d;
      hold_cnt   <= hold_cnt_d;
      core_reset <= rst_d;
    end
  end

  defender_coin_shaper #(
    .COIN_PULSE_CYC(COIN_PULSE_CYC),
    .COIN_GAP_CYC  (COIN_GAP_CYC)
  ) u_coin (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .coin_src(coin_src),
    .hold    (rst_d),
    .coin_out(coin_out),
    .state   (coin_state)
  );

  assign unused_bits = ^{joy[15:10], coin_state};

endmodule

// File: tb/tb_defender_input_ctrl.sv
// Directed bench for defender_input_ctrl: a key/joystick vector table followed by
// hand-written coin and reset sequences.
module tb_defender_input_ctrl;
  import defender_input_pkg::*;

  localparam int PULSE = 8;
  localparam int GAP   = 4;
  localparam int HOLD  = 5;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [64:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        reset_req;
  logic [11:0] btn;
  logic        coin_out;
  logic        core_reset;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic tgl      = 1'b0;

  typedef struct {
    logic        ev;
    logic [63:0] key;
    logic [15:0] j0;
    logic [15:0] j1;
    logic [11:0] exp_btn;
  } vec_t;

  vec_t vecs[$];

  always #5 clk_sys = ~clk_sys;

  defender_input_ctrl #(
    .COIN_PULSE_CYC(PULSE),
    .COIN_GAP_CYC  (GAP),
    .RST_HOLD_CYC  (HOLD)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_key   (ps2_key),
    .joystick_0(joystick_0),
    .joystick_1(joystick_1),
    .reset_req (reset_req),
    .btn       (btn),
    .coin_out  (coin_out),
    .core_reset(core_reset)
  );

  function automatic logic [63:0] kp(input logic [7:0] c);
    return {56'h0, c};
  endfunction
  function automatic logic [63:0] kx(input logic [7:0] c);
    return {48'h0, 8'hE0, c};
  endfunction
  function automatic logic [63:0] kr(input logic [7:0] c);
    return {48'h0, 8'hF0, c};
  endfunction
  function automatic logic [63:0] kxr(input logic [7:0] c);
    return {40'h0, 8'hE0, 8'hF0, c};
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic ev, input logic [63:0] key);
    if (ev) tgl = ~tgl;
    ps2_key = {tgl, key};
  endtask

  task automatic add(input logic ev, input logic [63:0] key, input logic [15:0] j0,
                     input logic [15:0] j1, input logic [11:0] exp_btn);
    vec_t v;
    v.ev = ev; v.key = key; v.j0 = j0; v.j1 = j1; v.exp_btn = exp_btn;
    vecs.push_back(v);
  endtask

  // Runs n cycles with inputs untouched, counting coin_out high samples and rises.
  task automatic coin_window(input int n, output int highs, output int rises);
    logic prev;
    prev  = coin_out;
    highs = 0;
    rises = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (coin_out) highs++;
      if (coin_out && !prev) rises++;
      prev = coin_out;
    end
  endtask

  initial begin
    int   highs;
    int   rises;
    logic prev;
    logic [19:0] pat;

    add(1, kp(8'h29), 16'h0, 16'h0, 12'h020);
    add(1, kr(8'h29), 16'h0, 16'h0, 12'h000);
    add(0, kp(8'h29), 16'h0, 16'h0, 12'h000);
    add(1, kp(8'h29), 16'h0, 16'h0, 12'h020);
    add(0, kr(8'h29), 16'h0, 16'h0, 12'h020);
    add(1, kr(8'h29), 16'h0, 16'h0, 12'h000);
    add(1, kx(8'h6B), 16'h0, 16'h0, 12'h040);
    add(1, kxr(8'h74), 16'h0, 16'h0, 12'h000);
    add(0, kxr(8'h74), 16'h0, 16'h0001, 12'h040);
    add(0, kxr(8'h74), 16'h0002, 16'h0, 12'h040);
    add(0, kxr(8'h74), 16'h0, 16'h0, 12'h000);
    add(1, kp(8'h29), 16'h0, 16'h0, 12'h020);
    add(1, kp(8'h6B), 16'h0, 16'h0, 12'h020);
    add(1, kr(8'h75), 16'h0, 16'h0, 12'h020);
    add(1, kx(8'h75), 16'h0, 16'h0, 12'h820);
    add(1, 64'h0000_0001_0000_F029, 16'h0, 16'h0, 12'h820);
    add(1, kxr(8'h75), 16'h0, 16'h0, 12'h020);
    add(1, kr(8'h29), 16'h0, 16'h0, 12'h000);
    add(1, kp(8'h12), 16'h0, 16'h0, 12'h200);
    add(1, kp(8'h59), 16'h0, 16'h0, 12'h200);
    add(1, kr(8'h12), 16'h0, 16'h0, 12'h000);
    add(1, kx(8'h72), 16'h0, 16'h0, 12'h400);
    add(1, kx(8'h14), 16'h0, 16'h0, 12'h480);
    add(1, kp(8'h1D), 16'h0, 16'h0, 12'h580);
    add(1, kp(8'h05), 16'h0, 16'h0, 12'h588);
    add(1, kp(8'h06), 16'h0, 16'h0, 12'h598);
    add(1, kp(8'h1C), 16'h0, 16'h0, 12'h599);
    add(1, kp(8'h3C), 16'h0, 16'h0, 12'h59B);
    add(1, kp(8'h33), 16'h0, 16'h0, 12'h59F);
    add(1, kp(8'h14), 16'h0, 16'h0, 12'h59F);
    add(0, kp(8'h14), 16'h01FC, 16'h0, 12'hFBF);
    add(0, kp(8'h14), 16'h0, 16'h0001, 12'h5DF);
    add(0, kp(8'h14), 16'h0, 16'h0, 12'h59F);
    add(1, kx(8'h29), 16'h0, 16'h0, 12'h59F);
    add(1, kx(8'h74), 16'h0, 16'h0, 12'h5DF);
    add(1, kxr(8'h6B), 16'h0, 16'h0, 12'h59F);

    // Power-on reset
    reset_n    = 1'b0;
    reset_req  = 1'b0;
    ps2_key    = '0;
    joystick_0 = '0;
    joystick_1 = '0;
    step();
    step();
    check("por btn", 32'(btn), 32'h0);
    check("por coin_out", 32'(coin_out), 32'h0);
    check("por core_reset", 32'(core_reset), 32'h1);
    check("por coin state", 32'(dut.coin_state), 32'(COIN_IDLE));
    reset_n = 1'b1;
    for (int i = 1; i <= HOLD; i++) begin
      step();
      check($sformatf("por hold c%0d", i), 32'(core_reset), 32'(i < HOLD));
    end

    foreach (vecs[i]) begin
      send(vecs[i].ev, vecs[i].key);
      joystick_0 = vecs[i].j0;
      joystick_1 = vecs[i].j1;
      step();
      check($sformatf("vec%0d btn", i), 32'(btn), 32'(vecs[i].exp_btn));
    end

    // reset_req for 3 cycles: core_reset high 3+HOLD cycles, joystick still visible
    joystick_1 = 16'h0020;
    reset_req  = 1'b1;
    for (int i = 1; i <= 3 + HOLD + 1; i++) begin
      step();
      check($sformatf("req hold c%0d", i), 32'(core_reset), 32'(i <= 3 + HOLD));
      if (i == 1) check("req btn joy only", 32'(btn), 32'h020);
      if (i == 3) reset_req = 1'b0;
    end
    check("latches cleared", 32'(btn), 32'h020);
    joystick_1 = '0;

    // Re-assert at hold cycle 2 restarts the full hold
    reset_req = 1'b1;
    step();
    reset_req = 1'b0;
    step();
    step();
    reset_req = 1'b1;
    step();
    reset_req = 1'b0;
    for (int i = 1; i <= HOLD + 1; i++) begin
      step();
      check($sformatf("restart c%0d", i), 32'(core_reset), 32'(i <= HOLD));
    end

    // Held joystick coin: one pulse, then WAIT_REL until released
    joystick_0 = 16'h0200;
    for (int i = 1; i <= 40; i++) begin
      step();
      check($sformatf("held coin c%0d", i), 32'(coin_out), 32'(i <= PULSE));
    end
    check("held coin wait_rel", 32'(dut.coin_state), 32'(COIN_WAIT_REL));
    joystick_0 = '0;
    step();
    check("release idle", 32'(dut.coin_state), 32'(COIN_IDLE));
    joystick_0 = 16'h0200;
    coin_window(16, highs, rises);
    check("repress highs", 32'(highs), 32'(PULSE));
    check("repress rises", 32'(rises), 32'h1);
    joystick_0 = '0;
    step();
    step();

    // Extra edges during PULSE (k=4) and GAP (k=9) are dropped
    pat   = 20'h00637;
    prev  = coin_out;
    highs = 0;
    rises = 0;
    for (int k = 0; k < 20; k++) begin
      joystick_0 = pat[k] ? 16'h0200 : 16'h0000;
      step();
      if (coin_out) highs++;
      if (coin_out && !prev) rises++;
      prev = coin_out;
    end
    check("drop edges highs", 32'(highs), 32'(PULSE));
    check("drop edges rises", 32'(rises), 32'h1);

    // Keyboard coin: latch then pulse one cycle later
    send(1, kp(8'h04));
    step();
    check("kbd coin latency", 32'(coin_out), 32'h0);
    coin_window(12, highs, rises);
    check("kbd coin highs", 32'(highs), 32'(PULSE));
    send(1, kr(8'h04));
    step();
    step();
    step();
    check("kbd coin idle", 32'(dut.coin_state), 32'(COIN_IDLE));

    // reset_req mid-PULSE drops coin_out with the rising core_reset
    joystick_0 = 16'h0200;
    step();
    step();
    step();
    check("mid pulse coin", 32'(coin_out), 32'h1);
    reset_req = 1'b1;
    step();
    check("req drop coin", 32'(coin_out), 32'h0);
    check("req drop core", 32'(core_reset), 32'h1);
    reset_req  = 1'b0;
    joystick_0 = '0;
    for (int i = 0; i < HOLD + 1; i++) step();
    check("after req core", 32'(core_reset), 32'h0);
    check("after req state", 32'(dut.coin_state), 32'(COIN_IDLE));

    // reset_n mid-PULSE
    joystick_0 = 16'h0200;
    joystick_1 = 16'h0020;
    step();
    step();
    step();
    check("pre rst coin", 32'(coin_out), 32'h1);
    check("pre rst btn", 32'(btn), 32'h020);
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst btn", 32'(btn), 32'h0);
    check("async rst coin", 32'(coin_out), 32'h0);
    check("async rst core", 32'(core_reset), 32'h1);
    check("async rst state", 32'(dut.coin_state), 32'(COIN_IDLE));
    joystick_0 = '0;
    joystick_1 = '0;
    step();
    reset_n = 1'b1;
    for (int i = 1; i <= HOLD; i++) begin
      step();
      check($sformatf("rst hold c%0d", i), 32'(core_reset), 32'(i < HOLD));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
